demux_rr_n: RTL
===============

# demux_rr_n

Parametrised round-robin demultiplexer for the `clk_2f` data path. It is the successor to the fixed 1-to-2, 8-bit demux. It distributes a serial stream of valid words from one input across `NUM_CH` output lanes of `WIDTH` bits each. It has two modes:
- **Immediate mode:** each word appears on its lane one cycle after it is accepted.
- **Aligned mode:** a full group of `NUM_CH` words is presented on all lanes in the same cycle.

Invalid input cycles never consume a lane. A `flush` input closes a partial group.

## Interface
- `WIDTH`, default 8: data word width, ≥1.
- `NUM_CH`, default 2: number of output lanes, ≥2; need not be a power of two.
- `MODE`, default 0: 0 = immediate, 1 = aligned (group).
- `PTR_W`, derived as `$clog2(NUM_CH)`, not overridable.

Ports:
- `clk_2f`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `data_in`, input, `WIDTH`: input word.
- `valid_in`, input, 1: `data_in` is accepted on this edge.
- `flush`, input, 1: close the current group or pointer cycle.
- `data_out`, output, `NUM_CH*WIDTH`: lane k is bits `[k*WIDTH +: WIDTH]`.
- `valid_out`, output, `NUM_CH`: bit k qualifies lane k for one cycle.
- `lane_ptr`, output, `PTR_W`: lane that the next accepted word goes to.

## Operation
- **Reset:** while `reset` = 0, the following are all cleared immediately, independent of the clock:
  - `data_out` = 0, `valid_out` = 0, `lane_ptr` = 0;
  - the staging registers and the staging mask.
- **Reset mid-operation:** a pending partial group is discarded and is never emitted.
- **Pointer:** advances only on an edge where `valid_in` = 1.
  - Wraps from `NUM_CH-1` to 0 by explicit compare, not by modulo-2^`PTR_W` overflow.
  - Holds on edges where `valid_in` = 0.
- **MODE 0, `valid_in` = 1:**
  - `data_out` lane[`lane_ptr`] ← `data_in`;
  - `valid_out` ← one-hot(`lane_ptr`);
  - `lane_ptr` ← next.
- **MODE 0, `valid_in` = 0:** `valid_out` ← 0 and all `data_out` lanes hold.
- **MODE 1, `valid_in` = 1:** staging[`lane_ptr`] ← `data_in` and mask[`lane_ptr`] ← 1.
  - If `lane_ptr` = `NUM_CH-1`, a group is emitted on the same edge:
    - `data_out` ← staging, with lane `NUM_CH-1` taken directly from `data_in`;
    - `valid_out` ← all ones;
    - mask ← 0 and `lane_ptr` ← 0.
  - Otherwise `valid_out` ← 0.
- **MODE 1 flush:** `flush` = 1 with a non-empty pending set (mask | current valid word) emits a partial group:
  - only the pending lanes load into `data_out`;
  - `valid_out` ← pending set;
  - lanes outside the pending set hold their previous `data_out` value;
  - mask ← 0 and `lane_ptr` ← 0.
- **MODE 0 flush:** the current valid word, if any, is routed normally, then `lane_ptr` ← 0.
- **Flush with nothing pending (either mode):** `lane_ptr` ← 0, `valid_out` ← 0, no data change.
- **Flush on the last lane in MODE 1:** identical to a normal full-group emit.
- **Idle behaviour:** `data_out` holds between emits and is never cleared except by reset.

## Timing
- MODE 0 latency: 1 cycle from the accepting edge to `data_out` / `valid_out`.
- MODE 0 throughput: one word per cycle.
- MODE 1 latency: 1 cycle after the edge accepting lane `NUM_CH-1`, or after the flush edge.
- MODE 1 group spacing: minimum `NUM_CH` cycles.
- `valid_out` pulses last exactly 1 cycle; back-to-back pulses are legal, including one-hot(k) followed by one-hot(k+1).
- `lane_ptr` is registered and reflects the state after the last edge.
- No combinational path from any input to any output.
- Reset deassertion is synchronised by the system. The first edge after deassertion behaves as a normal cycle with `lane_ptr` = 0.

## Test plan
- **Reset values:** WIDTH=8, NUM_CH=2, MODE=0; assert `reset`=0 mid-stream → immediately `data_out`=16'h0000, `valid_out`=2'b00, `lane_ptr`=0.
- **Immediate routing:** MODE=0, valid words 8'h24, 8'h81, 8'h09 on consecutive edges → next cycles show:
  - lane0=8'h24 with `valid_out`=01;
  - lane1=8'h81 with `valid_out`=10;
  - lane0=8'h09 with `valid_out`=01;
  - `lane_ptr` sequence 1, 0, 1.
- **Invalid gap:** MODE=0, `valid_in`=0 for 3 cycles carrying 8'h63 → `valid_out`=00, `data_out` unchanged, `lane_ptr` held; the next valid word lands on the held lane.
- **Non-power-of-two wrap:** NUM_CH=3, MODE=1, words 8'h0D, 8'h8D, 8'h65 → one cycle after the third, `data_out`={8'h65,8'h8D,8'h0D}, `valid_out`=3'b111, `lane_ptr`=0; no valid pulse during the first two.
- **Partial flush:** NUM_CH=3, MODE=1, words 8'h12, 8'h01, then `flush` alone → lanes 0/1 = 8'h12/8'h01, `valid_out`=3'b011, lane2 retains its old value, `lane_ptr`=0.
- **Reset discards partial group:** NUM_CH=3, MODE=1, one word 8'hAA then reset → no emit. The next three words emit cleanly as a group and 8'hAA never appears.

Source files
------------

// File: rtl/demux_rr_n.sv
// demux_rr_n: round-robin demultiplexer for the clk_2f data path.
// One serial word stream is spread across NUM_CH lanes of WIDTH bits.
// MODE 0 forwards each word to its lane one cycle after acceptance.
// MODE 1 stages words and presents a whole group on all lanes at once.
//
// Handshake: valid_in qualifies data_in on the rising edge of clk_2f; there
// is no backpressure, so every edge with valid_in=1 consumes exactly one lane.
// valid_out[k] qualifies data_out lane k for exactly one cycle.
module demux_rr_n #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 2,
  parameter int MODE   = 0,
  localparam int PTR_W = $clog2(NUM_CH)
) (
  input  logic                    clk_2f,
  input  logic                    reset,
  input  logic [WIDTH-1:0]        data_in,
  input  logic                    valid_in,
  input  logic                    flush,
  output logic [NUM_CH*WIDTH-1:0] data_out,
  output logic [NUM_CH-1:0]       valid_out,
  output logic [PTR_W-1:0]        lane_ptr
);

  // Registered state; every output comes straight from a register.
  logic [NUM_CH*WIDTH-1:0] r_data;
  logic [NUM_CH-1:0]       r_valid;
  logic [PTR_W-1:0]        r_ptr;
  logic [NUM_CH*WIDTH-1:0] r_stage;
  logic [NUM_CH-1:0]       r_mask;

  // Next-state values.
  logic [NUM_CH*WIDTH-1:0] w_data_nx;
  logic [NUM_CH-1:0]       w_valid_nx;
  logic [PTR_W-1:0]        w_ptr_nx;
  logic [NUM_CH*WIDTH-1:0] w_stage_nx;
  logic [NUM_CH-1:0]       w_mask_nx;

  // Helpers.
  logic                    w_last;
  logic [PTR_W-1:0]        w_ptr_inc;
  logic [NUM_CH-1:0]       w_onehot;
  logic [NUM_CH-1:0]       w_cur;
  logic [NUM_CH-1:0]       w_pend;
  logic [NUM_CH*WIDTH-1:0] w_stage_in;
  logic                    w_emit_full;
  logic                    w_emit;
  logic [NUM_CH-1:0]       w_emit_mask;

  assign w_onehot = {{(NUM_CH-1){1'b0}}, 1'b1} << r_ptr;

  // Pointer arithmetic, pending set and staging merged with the current word.
  always_comb begin
    w_last     = (r_ptr == PTR_W'(NUM_CH - 1));
    // Explicit wrap so non-power-of-two lane counts never reach unused codes.
    w_ptr_inc  = w_last ? '0 : r_ptr + PTR_W'(1);
    w_cur      = valid_in ? w_onehot : '0;
    w_pend     = r_mask | w_cur;
    w_stage_in = r_stage;
    for (int i = 0; i < NUM_CH; i++) begin
      if (valid_in && (PTR_W'(i) == r_ptr)) begin
        w_stage_in[i*WIDTH +: WIDTH] = data_in;
      end
    end
  end

  // Next-state selection for both modes.
  always_comb begin
    w_data_nx   = r_data;
    w_valid_nx  = '0;
    w_ptr_nx    = r_ptr;
    w_stage_nx  = r_stage;
    w_mask_nx   = r_mask;
    w_emit_full = 1'b0;
    w_emit      = 1'b0;
    w_emit_mask = '0;
    if (MODE == 0) begin
      // Immediate: route the word now; a flush only rewinds the pointer
      // after the current word has been placed.
      if (valid_in) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (PTR_W'(i) == r_ptr) begin
            w_data_nx[i*WIDTH +: WIDTH] = data_in;
          end
        end
        w_valid_nx = w_onehot;
        w_ptr_nx   = w_ptr_inc;
      end
      if (flush) begin
        w_ptr_nx = '0;
      end
    end else begin
      // Aligned: the last lane completes a group on the same edge; the
      // last lane's data comes from data_in through w_stage_in.
      w_stage_nx  = w_stage_in;
      w_emit_full = valid_in && w_last;
      w_emit      = w_emit_full || (flush && (|w_pend));
      w_emit_mask = w_emit_full ? {NUM_CH{1'b1}} : w_pend;
      if (w_emit) begin
        // Lanes outside the pending set keep their previous output.
        for (int i = 0; i < NUM_CH; i++) begin
          if (w_emit_mask[i]) begin
            w_data_nx[i*WIDTH +: WIDTH] = w_stage_in[i*WIDTH +: WIDTH];
          end
        end
        w_valid_nx = w_emit_mask;
        w_mask_nx  = '0;
        w_ptr_nx   = '0;
      end else begin
        w_mask_nx = w_pend;
        if (valid_in) begin
          w_ptr_nx = w_ptr_inc;
        end
        if (flush) begin
          w_ptr_nx = '0;
        end
      end
    end
  end

  // State registers; reset also throws away any partially staged group.
  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      r_data  <= '0;
      r_valid <= '0;
      r_ptr   <= '0;
      r_stage <= '0;
      r_mask  <= '0;
    end else begin
      r_data  <= w_data_nx;
      r_valid <= w_valid_nx;
      r_ptr   <= w_ptr_nx;
      r_stage <= w_stage_nx;
      r_mask  <= w_mask_nx;
    end
  end

  assign data_out  = r_data;
  assign valid_out = r_valid;
  assign lane_ptr  = r_ptr;

endmodule
